// File: rtl/sha3_pkg.sv
// Purpose: shared SHA-3/SHAKE padder types, mode tables and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sha3_pkg;

  // Keccak 5x5x64 state; lane x+5y lives at [y][x].
  typedef logic [0:4][0:4][63:0] state_t;

  typedef enum logic [2:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5,
    MODE_RSVD6    = 3'd6,
    MODE_RSVD7    = 3'd7
  } mode_t;

  // Codes 6 and 7 behave exactly like SHA3-256.
  localparam logic [7:0] RATE_BYTES [0:7] = '{
    8'd144, 8'd136, 8'd104, 8'd72, 8'd168, 8'd136, 8'd136, 8'd136
  };

  localparam logic [7:0] SUFFIX [0:7] = '{
    8'h06, 8'h06, 8'h06, 8'h06, 8'h1F, 8'h1F, 8'h06, 8'h06
  };

  localparam logic [7:0] PAD_FINAL = 8'h80;

  // Number of set bits in a (contiguous) keep mask.
  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sha3_pad_absorb_if.sv
// Purpose: message stream in / padded state block out bundle for the SHA-3 padder.
// Latency: n/a (wiring only).
// Backpressure: stream uses S_TVALID/S_TREADY, block output uses BLK_VALID/BLK_READY.
interface sha3_pad_absorb_if #(
  parameter int DATA_W = 64,
  parameter int MODE_W = 3
);
  import sha3_pkg::*;

  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] S_TDATA;
  logic [KEEP_W-1:0] S_TKEEP;
  logic              S_TLAST;
  logic [MODE_W-1:0] S_TUSER;
  logic              S_TVALID;
  logic              S_TREADY;

  state_t            BLK_DATA;
  logic              BLK_LAST;
  logic [MODE_W-1:0] BLK_MODE;
  logic              BLK_VALID;
  logic              BLK_READY;

  // Environment side: produces the message stream and consumes blocks.
  modport master (
    output S_TDATA, S_TKEEP, S_TLAST, S_TUSER, S_TVALID,
    input  S_TREADY,
    input  BLK_DATA, BLK_LAST, BLK_MODE, BLK_VALID,
    output BLK_READY
  );

  // Padder side: consumes the message stream and produces blocks.
  modport slave (
    input  S_TDATA, S_TKEEP, S_TLAST, S_TUSER, S_TVALID,
    output S_TREADY,
    output BLK_DATA, BLK_LAST, BLK_MODE, BLK_VALID,
    input  BLK_READY
  );

endinterface

// File: rtl/sha3_byte_writer.sv
// Purpose: combinational write-or-XOR of one byte into a Keccak state at a flat byte index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; en=0 passes the state through unchanged.
module sha3_byte_writer
  import sha3_pkg::*;
(
  input  state_t     st_in,
  input  logic [7:0] idx,
  input  logic [7:0] data,
  input  logic       en,
  input  logic       xor_en,
  output state_t     st_out
);

  // Decode idx into lane (idx/8) and little-endian byte within the lane.
  always_comb begin
    st_out = st_in;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        if (en && (idx[7:3] == 5'(x + 5 * y))) begin
          st_out[y][x][{idx[2:0], 3'b000} +: 8] = xor_en
            ? (st_in[y][x][{idx[2:0], 3'b000} +: 8] ^ data)
            : data;
        end
      end
    end
  end

endmodule

// File: rtl/sha3_pad_absorb.sv
// Purpose: SHA-3/SHAKE multi-rate padder assembling rate-sized Keccak blocks from a byte stream.
// Latency: block valid the cycle after its completing beat; an extra pad block adds one idle cycle.
// Backpressure: single block buffer; S_TREADY stays low while a block waits for BLK_READY.
module sha3_pad_absorb
  import sha3_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MODE_W = 3
) (
  input logic              ACLK,
  input logic              ARESET,
  sha3_pad_absorb_if.slave bus
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {FILL, FULL, PREP, PAD} fsm_t;

  fsm_t              state;
  state_t            blk_q;
  logic [7:0]        ptr;
  logic [MODE_W-1:0] mode_q;
  logic              msg_active;
  logic              pad_pending;
  logic              ready_q;
  logic              valid_q;
  logic              last_q;

  logic              tready;
  logic              accept;
  logic [2:0]        mode_idx;
  logic [7:0]        rate;
  logic [7:0]        suffix;
  logic [7:0]        nbytes;
  logic [7:0]        ptr_nxt;
  logic [7:0]        pad_idx;
  logic              pad_en;
  logic              tail_fits;
  state_t            sfx_st;
  state_t            blk_nxt;

  // Ready is masked by reset so the stream is closed during reset yet
  // opens in the very first cycle after it.
  assign tready   = ready_q & ~ARESET;
  assign accept   = tready & bus.S_TVALID;

  // The first beat of a message picks the mode; later beats use the latched copy.
  assign mode_idx = msg_active ? mode_q[2:0] : bus.S_TUSER[2:0];
  assign rate     = RATE_BYTES[mode_idx];
  assign suffix   = SUFFIX[mode_idx];

  // Non-last beats always carry a full word regardless of TKEEP.
  assign nbytes    = bus.S_TLAST ? popcount8(8'(bus.S_TKEEP)) : 8'(KEEP_W);
  assign ptr_nxt   = ptr + nbytes;
  assign tail_fits = ptr_nxt < rate;

  // The extra pad block is built as an empty tail at byte 0 of a cleared buffer.
  assign pad_en  = (state == PREP) | (accept & bus.S_TLAST & tail_fits);
  assign pad_idx = (state == PREP) ? 8'd0 : ptr_nxt;

  // Byte writers chained per beat byte; each stage feeds the next.
  for (genvar k = 0; k < KEEP_W; k++) begin : g_wr
    state_t st_i;
    state_t st_o;
    if (k == 0) begin : g_first
      assign st_i = blk_q;
    end else begin : g_next
      assign st_i = g_wr[k-1].st_o;
    end
    sha3_byte_writer u_data_wr (
      .st_in  (st_i),
      .idx    (ptr + 8'(k)),
      .data   (bus.S_TDATA[8*k +: 8]),
      .en     (accept & (8'(k) < nbytes)),
      .xor_en (1'b0),
      .st_out (st_o)
    );
  end

  // Domain suffix right after the last message byte.
  sha3_byte_writer u_sfx_wr (
    .st_in  (g_wr[KEEP_W-1].st_o),
    .idx    (pad_idx),
    .data   (suffix),
    .en     (pad_en),
    .xor_en (1'b1),
    .st_out (sfx_st)
  );

  // Closing 0x80 in the last rate byte; XOR merges it with the suffix when they coincide.
  sha3_byte_writer u_fin_wr (
    .st_in  (sfx_st),
    .idx    (rate - 8'd1),
    .data   (PAD_FINAL),
    .en     (pad_en),
    .xor_en (1'b1),
    .st_out (blk_nxt)
  );

  assign bus.S_TREADY  = tready;
  assign bus.BLK_VALID = valid_q;
  assign bus.BLK_DATA  = blk_q;
  assign bus.BLK_LAST  = last_q;
  assign bus.BLK_MODE  = mode_q;

  // Block assembly FSM: fill from the stream, hold a full block, optionally emit a pad-only block.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= FILL;
      blk_q       <= '0;
      ptr         <= '0;
      mode_q      <= '0;
      msg_active  <= 1'b0;
      pad_pending <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            blk_q <= blk_nxt;
            ptr   <= ptr_nxt;
            if (!msg_active) begin
              mode_q     <= bus.S_TUSER;
              msg_active <= 1'b1;
            end
            if (bus.S_TLAST || !tail_fits) begin
              state       <= FULL;
              ready_q     <= 1'b0;
              valid_q     <= 1'b1;
              last_q      <= bus.S_TLAST & tail_fits;
              pad_pending <= bus.S_TLAST & ~tail_fits;
            end
          end
        end
        FULL: begin
          if (bus.BLK_READY) begin
            valid_q <= 1'b0;
            blk_q   <= '0;
            ptr     <= '0;
            if (pad_pending) begin
              pad_pending <= 1'b0;
              state       <= PREP;
            end else begin
              if (last_q) begin
                msg_active <= 1'b0;
              end
              last_q  <= 1'b0;
              ready_q <= 1'b1;
              state   <= FILL;
            end
          end
        end
        PREP: begin
          blk_q   <= blk_nxt;
          valid_q <= 1'b1;
          last_q  <= 1'b1;
          state   <= PAD;
        end
        PAD: begin
          if (bus.BLK_READY) begin
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            blk_q      <= '0;
            msg_active <= 1'b0;
            ready_q    <= 1'b1;
            state      <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_pad_absorb.sv
// Purpose: directed self-checking bench for the SHA-3 padder with hand-computed blocks.
// Latency: checks block valid one cycle after the completing beat and the pad-block bubble.
// Backpressure: stalls BLK_READY and checks the stream stays closed without losing beats.
module tb_sha3_pad_absorb;
  import sha3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sha3_pad_absorb_if #(.DATA_W(64), .MODE_W(3)) bus ();

  sha3_pad_absorb #(.DATA_W(64), .MODE_W(3)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  localparam logic [63:0] MSB80 = 64'h8000_0000_0000_0000;

  function automatic state_t put_lane(input state_t s, input int l, input logic [63:0] v);
    state_t r;
    r = s;
    r[l/5][l%5] = v;
    return r;
  endfunction

  function automatic int first_diff(input state_t a, input state_t b);
    for (int l = 0; l < 25; l++) begin
      if (a[l/5][l%5] !== b[l/5][l%5]) return l;
    end
    return 0;
  endfunction

  // Present one beat and hold it until accepted; returns at the negedge after acceptance.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [2:0] u);
    int guard;
    guard = 0;
    bus.S_TDATA  = d;
    bus.S_TKEEP  = k;
    bus.S_TLAST  = l;
    bus.S_TUSER  = u;
    bus.S_TVALID = 1'b1;
    while (bus.S_TREADY !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: S_TREADY=%b required 1", bus.S_TREADY);
    end
    @(negedge clk);
    bus.S_TVALID = 1'b0;
  endtask

  // Wait for a block (BLK_READY assumed high), capture it, return after its handshake.
  task automatic get_block(output state_t d, output logic l, output logic [2:0] m);
    int guard;
    guard = 0;
    while (bus.BLK_VALID !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL block_timeout: BLK_VALID=%b required 1", bus.BLK_VALID);
    end
    d = bus.BLK_DATA;
    l = bus.BLK_LAST;
    m = bus.BLK_MODE;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.S_TVALID = 1'b0; bus.S_TDATA = '0; bus.S_TKEEP = '0;
    bus.S_TLAST = 1'b0; bus.S_TUSER = '0; bus.BLK_READY = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.S_TREADY !== 1'b0) begin fails++; $display("FAIL rst_tready: got %b required 0", bus.S_TREADY); end
    tests++; if (bus.BLK_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", bus.BLK_VALID); end
    tests++; if (bus.BLK_LAST !== 1'b0) begin fails++; $display("FAIL rst_last: got %b required 0", bus.BLK_LAST); end
    tests++; if (bus.BLK_MODE !== 3'd0) begin fails++; $display("FAIL rst_mode: got %0d required 0", bus.BLK_MODE); end
    tests++; if (bus.BLK_DATA !== '0) begin fails++; $display("FAIL rst_data: nonzero block after reset"); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.S_TREADY !== 1'b1) begin fails++; $display("FAIL post_rst_tready: got %b required 1", bus.S_TREADY); end
  endtask

  task automatic test_empty();
    state_t d, e; logic l; logic [2:0] m; int i;
    e = '0; e = put_lane(e, 0, 64'h06); e = put_lane(e, 16, MSB80);
    send_beat(64'h0, 8'h00, 1'b1, 3'd1);
    tests++; if (bus.BLK_VALID !== 1'b1) begin fails++; $display("FAIL empty_latency: BLK_VALID=%b required 1", bus.BLK_VALID); end
    tests++; if (bus.S_TREADY !== 1'b0) begin fails++; $display("FAIL empty_tready: got %b required 0", bus.S_TREADY); end
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL empty_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (l !== 1'b1) begin fails++; $display("FAIL empty_last: got %b required 1", l); end
    tests++; if (m !== 3'd1) begin fails++; $display("FAIL empty_mode: got %0d required 1", m); end
    tests++; if (bus.S_TREADY !== 1'b1) begin fails++; $display("FAIL empty_reopen: S_TREADY=%b required 1", bus.S_TREADY); end
  endtask

  // "abc" under SHA3-256 and under reserved code 7, which must behave identically.
  task automatic test_abc();
    state_t d, e; logic l; logic [2:0] m; int i;
    logic [2:0] modes [0:1];
    modes = '{3'd1, 3'd7};
    e = '0; e = put_lane(e, 0, 64'h0000_0000_0663_6261); e = put_lane(e, 16, MSB80);
    for (int t = 0; t < 2; t++) begin
      send_beat(64'h0000_0000_0063_6261, 8'h07, 1'b1, modes[t]);
      get_block(d, l, m);
      tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL abc_data[%0d]: lane %0d got %h required %h", t, i, d[i/5][i%5], e[i/5][i%5]); end
      tests++; if (l !== 1'b1) begin fails++; $display("FAIL abc_last[%0d]: got %b required 1", t, l); end
      tests++; if (m !== modes[t]) begin fails++; $display("FAIL abc_mode[%0d]: got %0d required %0d", t, m, modes[t]); end
    end
  endtask

  // Empty messages in other rates: final-byte lane moves with the rate, suffix with the domain.
  task automatic test_rates();
    state_t d, e; logic l; logic [2:0] m; int i;
    logic [2:0] modes [0:2];
    int lanes [0:2];
    logic [63:0] sfx [0:2];
    modes = '{3'd0, 3'd2, 3'd5};
    lanes = '{17, 12, 16};
    sfx   = '{64'h06, 64'h06, 64'h1F};
    for (int t = 0; t < 3; t++) begin
      e = '0; e = put_lane(e, 0, sfx[t]); e = put_lane(e, lanes[t], MSB80);
      send_beat(64'h0, 8'h00, 1'b1, modes[t]);
      get_block(d, l, m);
      tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL rate_data[%0d]: lane %0d got %h required %h", t, i, d[i/5][i%5], e[i/5][i%5]); end
      tests++; if (m !== modes[t]) begin fails++; $display("FAIL rate_mode[%0d]: got %0d required %0d", t, m, modes[t]); end
    end
  endtask

  // SHA3-512 message of exactly one rate (72 bytes) needs a pad-only second block.
  task automatic test_extra_block();
    state_t d, e; logic l; logic [2:0] m; int i; logic [63:0] w;
    e = '0;
    for (int b = 0; b < 9; b++) begin
      w = {8{8'(8'h10 + b)}};
      e = put_lane(e, b, w);
      send_beat(w, 8'hFF, (b == 8), 3'd3);
    end
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL xblk1_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (l !== 1'b0) begin fails++; $display("FAIL xblk1_last: got %b required 0", l); end
    tests++; if (bus.BLK_VALID !== 1'b0) begin fails++; $display("FAIL xblk_bubble: BLK_VALID=%b required 0", bus.BLK_VALID); end
    tests++; if (bus.S_TREADY !== 1'b0) begin fails++; $display("FAIL xblk_tready_bubble: got %b required 0", bus.S_TREADY); end
    @(negedge clk);
    tests++; if (bus.S_TREADY !== 1'b0) begin fails++; $display("FAIL xblk_tready_pad: got %b required 0", bus.S_TREADY); end
    e = '0; e = put_lane(e, 0, 64'h06); e = put_lane(e, 8, MSB80);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL xblk2_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (l !== 1'b1) begin fails++; $display("FAIL xblk2_last: got %b required 1", l); end
    tests++; if (m !== 3'd3) begin fails++; $display("FAIL xblk2_mode: got %0d required 3", m); end
  endtask

  // SHAKE128, 167 bytes: suffix and final bit share byte 167 (0x9F). First beat has a
  // partial TKEEP on a non-last beat, which must still be taken as a full word.
  task automatic test_shake128_tail();
    state_t d, e; logic l; logic [2:0] m; int i; logic [63:0] w;
    e = '0;
    for (int b = 0; b < 20; b++) begin
      w = {8{8'(b + 1)}};
      e = put_lane(e, b, w);
      send_beat(w, (b == 0) ? 8'h0F : 8'hFF, 1'b0, 3'd4);
    end
    e = put_lane(e, 20, 64'h9FAA_AAAA_AAAA_AAAA);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h7F, 1'b1, 3'd4);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL s128_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (l !== 1'b1) begin fails++; $display("FAIL s128_last: got %b required 1", l); end
    tests++; if (bus.BLK_VALID !== 1'b0) begin fails++; $display("FAIL s128_single: BLK_VALID=%b required 0", bus.BLK_VALID); end
  endtask

  task automatic test_backpressure();
    state_t d, e, snap; logic l; logic [2:0] m; int i;
    logic stable, closed, held;
    bus.BLK_READY = 1'b0;
    send_beat(64'h0000_0000_0063_6261, 8'h07, 1'b1, 3'd1);
    snap = bus.BLK_DATA;
    stable = 1'b1; closed = 1'b1; held = 1'b1;
    bus.S_TDATA = 64'h55; bus.S_TKEEP = 8'h01; bus.S_TLAST = 1'b1; bus.S_TUSER = 3'd1; bus.S_TVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.BLK_DATA !== snap) stable = 1'b0;
      if (bus.S_TREADY !== 1'b0) closed = 1'b0;
      if (bus.BLK_VALID !== 1'b1) held = 1'b0;
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable: stable=%b required 1", stable); end
    tests++; if (closed !== 1'b1) begin fails++; $display("FAIL bp_tready: closed=%b required 1", closed); end
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL bp_valid: held=%b required 1", held); end
    e = '0; e = put_lane(e, 0, 64'h0000_0000_0663_6261); e = put_lane(e, 16, MSB80);
    tests++; if (snap !== e) begin fails++; i = first_diff(snap, e); $display("FAIL bp_data: lane %0d got %h required %h", i, snap[i/5][i%5], e[i/5][i%5]); end
    bus.BLK_READY = 1'b1;
    send_beat(64'h55, 8'h01, 1'b1, 3'd1);
    e = '0; e = put_lane(e, 0, 64'h0655); e = put_lane(e, 16, MSB80);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL bp_next_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
  endtask

  task automatic test_reset_mid();
    state_t d, e; logic l; logic [2:0] m; int i; logic quiet;
    for (int b = 0; b < 5; b++) send_beat({8{8'(8'hC0 + b)}}, 8'hFF, 1'b0, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (bus.BLK_VALID !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b required 0", bus.BLK_VALID); end
    tests++; if (bus.S_TREADY !== 1'b0) begin fails++; $display("FAIL mid_rst_tready: got %b required 0", bus.S_TREADY); end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.BLK_VALID !== 1'b0) quiet = 1'b0;
    end
    tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL mid_rst_quiet: quiet=%b required 1", quiet); end
    send_beat(64'h7A, 8'h01, 1'b1, 3'd1);
    e = '0; e = put_lane(e, 0, 64'h067A); e = put_lane(e, 16, MSB80);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL mid_rst_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (l !== 1'b1) begin fails++; $display("FAIL mid_rst_last: got %b required 1", l); end
  endtask

  // Two messages back to back; TUSER on the second beat of the first must be ignored.
  task automatic test_back_to_back();
    state_t d, e; logic l; logic [2:0] m; int i;
    send_beat(64'h0807_0605_0403_0201, 8'hFF, 1'b0, 3'd2);
    send_beat(64'h0000_0000_0000_BBAA, 8'h03, 1'b1, 3'd4);
    e = '0;
    e = put_lane(e, 0, 64'h0807_0605_0403_0201);
    e = put_lane(e, 1, 64'h0000_0000_0006_BBAA);
    e = put_lane(e, 12, MSB80);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL b2b1_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (m !== 3'd2) begin fails++; $display("FAIL b2b1_mode: got %0d required 2", m); end
    send_beat(64'h0, 8'h00, 1'b1, 3'd4);
    e = '0; e = put_lane(e, 0, 64'h1F); e = put_lane(e, 20, MSB80);
    get_block(d, l, m);
    tests++; if (d !== e) begin fails++; i = first_diff(d, e); $display("FAIL b2b2_data: lane %0d got %h required %h", i, d[i/5][i%5], e[i/5][i%5]); end
    tests++; if (m !== 3'd4) begin fails++; $display("FAIL b2b2_mode: got %0d required 4", m); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_rates();
    test_extra_block();
    test_shake128_tail();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
